alu_mc_control: RTL and testbench

- Multi-cycle control unit that drives the 32-bit ALU.
- Sequences each MIPS-subset instruction through fetch/decode/execute/memory/writeback states.
- Issues the 4-bit ALU control code and datapath selects.
- Consumes the ALU Zero flag to resolve conditional branches.
- Sits between the instruction register (Op/Funct fields) and the processor datapath.

---
 rtl/alu_mc_control.sv | 187 ++++++++++++++++++
 tb/tb_alu_mc_control.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mc_control.sv
// Multi-cycle MIPS-subset control FSM for the 32-bit ALU datapath.
// The state register holds all sequencing; outputs are decoded from the state.
module alu_mc_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  output logic [3:0]       ctrl,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             PCWrite,
  output logic [1:0]       PCSource,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Illegal,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] InstrCount
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11,
    ILL    = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_J    = 6'h02;

  localparam logic [3:0] ALU_AND = 4'd0;
  localparam logic [3:0] ALU_OR  = 4'd1;
  localparam logic [3:0] ALU_ADD = 4'd2;
  localparam logic [3:0] ALU_SUB = 4'd6;
  localparam logic [3:0] ALU_SLT = 4'd7;

  state_t state;
  state_t next_state;
  logic   funct_ok;
  logic [3:0] funct_ctrl;
  logic   retire;

  always_comb begin
    funct_ok   = 1'b1;
    funct_ctrl = ALU_ADD;
    case (Funct)
      6'h20:   funct_ctrl = ALU_ADD;
      6'h22:   funct_ctrl = ALU_SUB;
      6'h24:   funct_ctrl = ALU_AND;
      6'h25:   funct_ctrl = ALU_OR;
      6'h2A:   funct_ctrl = ALU_SLT;
      default: funct_ok   = 1'b0;
    endcase
  end

  always_comb begin
    next_state = FETCH;
    case (state)
      FETCH: next_state = DECODE;
      DECODE: begin
        case (Op)
          OP_LW, OP_SW:   next_state = MEMADR;
          OP_R:           next_state = funct_ok ? REXEC : ILL;
          OP_BEQ, OP_BNE: next_state = BRANCH;
          OP_ADDI:        next_state = ADDIEX;
          OP_J:           next_state = JUMP;
          default:        next_state = ILL;
        endcase
      end
      // Op is held stable from DECODE; anything else here means a broken
      // instruction register, so just abandon the instruction.
      MEMADR: begin
        if (Op == OP_LW)      next_state = MEMRD;
        else if (Op == OP_SW) next_state = MEMWR;
        else                  next_state = FETCH;
      end
      MEMRD:   next_state = MEMWB;
      REXEC:   next_state = RWB;
      ADDIEX:  next_state = ADDIWB;
      default: next_state = FETCH;
    endcase
  end

  // An instruction retires on any return to FETCH, illegal ones included.
  assign retire = (state != FETCH) && (next_state == FETCH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FETCH;
      InstrCount <= '0;
    end else begin
      state <= next_state;
      if (retire) InstrCount <= InstrCount + CNT_W'(1);
    end
  end

  assign State = state;

  always_comb begin
    ctrl     = ALU_AND;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'd0;
    PCWrite  = 1'b0;
    PCSource = 2'd0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    Illegal  = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        ALUSrcB = 2'd1;
        ctrl    = ALU_ADD;
        PCWrite = 1'b1;
      end
      DECODE: begin
        ALUSrcB = 2'd3;
        ctrl    = ALU_ADD;
      end
      MEMADR, ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        ctrl    = ALU_ADD;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      REXEC: begin
        ALUSrcA = 1'b1;
        ctrl    = funct_ctrl;
      end
      RWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA  = 1'b1;
        ctrl     = ALU_SUB;
        PCSource = 2'd1;
        PCWrite  = ((Op == OP_BEQ) && Zero) || ((Op == OP_BNE) && !Zero);
      end
      ADDIWB:  RegWrite = 1'b1;
      JUMP: begin
        PCSource = 2'd2;
        PCWrite  = 1'b1;
      end
      ILL:     Illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_mc_control.sv
// Directed bench for alu_mc_control: a per-instruction phase model builds the
// expected output trace, a negedge process compares it cycle by cycle.
module tb_alu_mc_control;
  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [5:0] Op = '0;
  logic [5:0] Funct = '0;
  logic Zero = 1'b0;
  logic [3:0] ctrl;
  logic ALUSrcA;
  logic [1:0] ALUSrcB;
  logic PCWrite;
  logic [1:0] PCSource;
  logic IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, Illegal;
  logic [3:0] State;
  logic [CNT_W-1:0] InstrCount;

  alu_mc_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
    .ctrl(ctrl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCWrite(PCWrite),
    .PCSource(PCSource), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .Illegal(Illegal), .State(State), .InstrCount(InstrCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic [3:0] ctrl;
    logic       asa;
    logic [1:0] asb;
    logic       pcw;
    logic [1:0] pcs;
    logic       iord, mr, mw, irw, rd, m2r, rw, ill;
    logic [CNT_W-1:0] cnt;
  } rec_t;

  rec_t  act;
  rec_t  exp_q[$];
  string lbl_q[$];
  int errors = 0;
  int checks = 0;
  logic [CNT_W-1:0] m_count = '0;

  assign act = {State, ctrl, ALUSrcA, ALUSrcB, PCWrite, PCSource, IorD, MemRead,
                MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, Illegal, InstrCount};

  // Compare process: one expected record per cycle, skipped while in reset.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      rec_t  e;
      string l;
      e = exp_q.pop_front();
      l = lbl_q.pop_front();
      if (!reset) begin
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL %s state=%0d: got %h want %h", l, e.st, act, e);
        end
      end
    end
  end

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  function automatic rec_t r(int st, int c, int asa, int asb, int pcw, int pcs,
                             int iord, int mr, int mw, int irw, int rd, int m2r,
                             int rw, int ill);
    rec_t x;
    x.st = 4'(st); x.ctrl = 4'(c); x.asa = 1'(asa); x.asb = 2'(asb);
    x.pcw = 1'(pcw); x.pcs = 2'(pcs); x.iord = 1'(iord); x.mr = 1'(mr);
    x.mw = 1'(mw); x.irw = 1'(irw); x.rd = 1'(rd); x.m2r = 1'(m2r);
    x.rw = 1'(rw); x.ill = 1'(ill); x.cnt = m_count;
    return x;
  endfunction

  function automatic rec_t p_fetch();  return r(0, 2, 0, 1, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0); endfunction
  function automatic rec_t p_decode(); return r(1, 2, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic rec_t p_memadr(); return r(2, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endfunction
  function automatic rec_t p_memwr();  return r(5, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0); endfunction
  function automatic rec_t p_ill();    return r(12, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endfunction

  function automatic int funct_alu(logic [5:0] fn);
    case (fn)
      6'h20: return 2;
      6'h22: return 6;
      6'h24: return 0;
      6'h25: return 1;
      6'h2A: return 7;
      default: return -1;
    endcase
  endfunction

  task automatic step(input rec_t e, input string l);
    exp_q.push_back(e);
    lbl_q.push_back(l);
    @(posedge clk);
    #1;
  endtask

  // Runs one whole instruction from its FETCH cycle; returns its cycle count.
  task automatic run_instr(input string name, input logic [5:0] op,
                           input logic [5:0] fn, input logic z, output int ncyc);
    rec_t seq[$];
    int fc;
    Op = op; Funct = fn; Zero = z;
    fc = funct_alu(fn);
    seq.push_back(p_fetch());
    seq.push_back(p_decode());
    case (op)
      6'h23: begin
        seq.push_back(p_memadr());
        seq.push_back(r(3, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0));
        seq.push_back(r(4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0));
      end
      6'h2B: begin
        seq.push_back(p_memadr());
        seq.push_back(p_memwr());
      end
      6'h00: begin
        if (fc >= 0) begin
          seq.push_back(r(6, fc, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
          seq.push_back(r(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        end else seq.push_back(p_ill());
      end
      6'h04, 6'h05: begin
        int taken;
        taken = (op == 6'h04) ? int'(z) : int'(!z);
        seq.push_back(r(8, 6, 1, 0, taken, 1, 0, 0, 0, 0, 0, 0, 0, 0));
      end
      6'h08: begin
        seq.push_back(r(9, 2, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        seq.push_back(r(10, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      end
      6'h02: seq.push_back(r(11, 0, 0, 0, 1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
      default: seq.push_back(p_ill());
    endcase
    ncyc = seq.size();
    foreach (seq[i]) step(seq[i], name);
    m_count = m_count + 1'b1;
  endtask

  typedef struct {
    string name;
    logic [5:0] op;
    logic [5:0] fn;
    logic z;
    int lat;
  } vec_t;

  initial begin
    int n;
    vec_t v[$];
    #1;
    chk("async reset state", State, 0);
    chk("async reset count", InstrCount, 0);
    @(posedge clk); #1;
    chk("reset MemRead", MemRead, 1);
    chk("reset IRWrite", IRWrite, 1);
    chk("reset PCWrite", PCWrite, 1);
    chk("reset ALUSrcB", ALUSrcB, 1);
    chk("reset ctrl", ctrl, 2);
    chk("reset RegWrite", RegWrite, 0);
    reset = 1'b0;

    run_instr("sub", 6'h00, 6'h22, 1'b0, n);
    chk("lat sub", n, 4);
    chk("count after sub", InstrCount, 1);

    // sw aborted by reset while in MEMWR
    Op = 6'h2B; Funct = '0; Zero = 1'b0;
    step(p_fetch(), "sw-abort");
    step(p_decode(), "sw-abort");
    step(p_memadr(), "sw-abort");
    exp_q.push_back(p_memwr());
    lbl_q.push_back("sw-abort");
    #1;
    chk("abort MemWrite before", MemWrite, 1);
    chk("abort state before", State, 5);
    #1 reset = 1'b1;
    #1;
    chk("abort MemWrite", MemWrite, 0);
    chk("abort state", State, 0);
    chk("abort count", InstrCount, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_count = '0;

    v.push_back('{"lw",    6'h23, 6'h00, 1'b0, 5});
    v.push_back('{"sw",    6'h2B, 6'h00, 1'b0, 4});
    v.push_back('{"add",   6'h00, 6'h20, 1'b0, 4});
    v.push_back('{"and",   6'h00, 6'h24, 1'b0, 4});
    v.push_back('{"or",    6'h00, 6'h25, 1'b0, 4});
    v.push_back('{"slt",   6'h00, 6'h2A, 1'b0, 4});
    v.push_back('{"addi",  6'h08, 6'h11, 1'b0, 4});
    v.push_back('{"beq z1", 6'h04, 6'h00, 1'b1, 3});
    v.push_back('{"beq z0", 6'h04, 6'h00, 1'b0, 3});
    v.push_back('{"bne z0", 6'h05, 6'h00, 1'b0, 3});
    v.push_back('{"bne z1", 6'h05, 6'h00, 1'b1, 3});
    v.push_back('{"ill op", 6'h3F, 6'h00, 1'b0, 3});
    v.push_back('{"ill fn", 6'h00, 6'h07, 1'b0, 3});
    v.push_back('{"j",     6'h02, 6'h00, 1'b0, 3});
    foreach (v[i]) begin
      run_instr(v[i].name, v[i].op, v[i].fn, v[i].z, n);
      chk({"lat ", v[i].name}, n, v[i].lat);
    end
    chk("count after directed", InstrCount, 14);

    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_count = '0;
    for (int k = 0; k < 16; k++) begin
      run_instr("j-wrap", 6'h02, 6'h00, 1'b0, n);
      if (k == 14) chk("count at 15", InstrCount, 15);
    end
    chk("count wrapped", InstrCount, 0);

    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

endmodule
